pipe_hazard_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 5-stage RV64 pipeline. Drives the enable and flush/bubble controls
//  of PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers from load-use, taken-branch and data-memory handshake

---
 rtl/pipe_pkg.sv | 13 +
 rtl/pipe_hazard_ctrl_hazard_detect.sv | 24 ++
 rtl/pipe_hazard_ctrl.sv | 147 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and constants for the pipeline hazard control slice
package pipe_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 64;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } pctl_state_t;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// rtl/pipe_hazard_ctrl_hazard_detect.sv - load-use hazard compare between ID sources and EX load destination
module hazard_detect
  import pipe_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] i_rs1,
  input  logic [REG_ADDR_W-1:0] i_rs2,
  input  logic                  i_rs1_used,
  input  logic                  i_rs2_used,
  input  logic [REG_ADDR_W-1:0] i_ex_rd,
  input  logic                  i_ex_mem_read,
  output logic                  o_load_use
);

  logic w_rs1_hit;
  logic w_rs2_hit;

  // x0 never carries a real dependency, so a load to x0 cannot stall
  always_comb begin
    w_rs1_hit  = i_rs1_used && (i_rs1 == i_ex_rd);
    w_rs2_hit  = i_rs2_used && (i_rs2 == i_ex_rd);
    o_load_use = i_ex_mem_read && (i_ex_rd != '0) && (w_rs1_hit || w_rs2_hit);
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush sequencer with dmem wait FSM, timeout and perf counters
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int TIMEOUT = 256,
  parameter int CNT_W   = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] if_id_rs1,
  input  logic [REG_ADDR_W-1:0] if_id_rs2,
  input  logic                  if_id_rs1_used,
  input  logic                  if_id_rs2_used,
  input  logic [REG_ADDR_W-1:0] id_ex_rd,
  input  logic                  id_ex_mem_read,
  input  logic                  ex_branch_taken,
  input  logic                  ex_mem_mem_req,
  input  logic                  dmem_ack,
  output logic                  dmem_req,
  output logic                  pc_en,
  output logic                  if_id_en,
  output logic                  if_id_flush,
  output logic                  id_ex_en,
  output logic                  id_ex_flush,
  output logic                  ex_mem_en,
  output logic                  mem_wb_bubble,
  output logic                  mem_err,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  localparam int TW = $clog2(TIMEOUT);

  pctl_state_t    r_state;
  pctl_state_t    w_next_state;
  logic [TW-1:0]  r_wait_cnt;
  logic           r_mem_err;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic           w_load_use;
  logic           w_mem_stall;
  logic           w_flush_inc;

  hazard_detect u_hazard_detect (
    .i_rs1         (if_id_rs1),
    .i_rs2         (if_id_rs2),
    .i_rs1_used    (if_id_rs1_used),
    .i_rs2_used    (if_id_rs2_used),
    .i_ex_rd       (id_ex_rd),
    .i_ex_mem_read (id_ex_mem_read),
    .o_load_use    (w_load_use)
  );

  // State register; ERR is only left through reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= RUN;
    else     r_state <= w_next_state;
  end

  // Next state plus same-cycle pipeline controls, priority ERR > mem stall > branch > load-use
  always_comb begin
    w_next_state  = r_state;
    w_mem_stall   = ex_mem_mem_req && !dmem_ack;
    w_flush_inc   = 1'b0;
    dmem_req      = ex_mem_mem_req;
    pc_en         = 1'b1;
    if_id_en      = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_en      = 1'b1;
    id_ex_flush   = 1'b0;
    ex_mem_en     = 1'b1;
    mem_wb_bubble = 1'b0;

    case (r_state)
      RUN: begin
        if (w_mem_stall) w_next_state = MEM_WAIT;
      end
      MEM_WAIT: begin
        // a request withdrawn without ack is tolerated and simply ends the wait
        if (dmem_ack || !ex_mem_mem_req)           w_next_state = RUN;
        else if (r_wait_cnt == TW'(TIMEOUT - 1))   w_next_state = ERR;
      end
      default: w_next_state = ERR;
    endcase

    if (rst) begin
      dmem_req      = 1'b0;
      pc_en         = 1'b0;
      if_id_en      = 1'b0;
      if_id_flush   = 1'b1;
      id_ex_en      = 1'b0;
      id_ex_flush   = 1'b1;
      ex_mem_en     = 1'b0;
      mem_wb_bubble = 1'b1;
    end else if (r_state == ERR) begin
      dmem_req      = 1'b0;
      pc_en         = 1'b0;
      if_id_en      = 1'b0;
      id_ex_en      = 1'b0;
      ex_mem_en     = 1'b0;
      mem_wb_bubble = 1'b1;
    end else if (w_mem_stall) begin
      pc_en         = 1'b0;
      if_id_en      = 1'b0;
      id_ex_en      = 1'b0;
      ex_mem_en     = 1'b0;
      mem_wb_bubble = 1'b1;
    end else if (ex_branch_taken) begin
      if_id_flush   = 1'b1;
      id_ex_flush   = 1'b1;
      w_flush_inc   = 1'b1;
    end else if (w_load_use) begin
      pc_en         = 1'b0;
      if_id_en      = 1'b0;
      id_ex_flush   = 1'b1;
    end
  end

  // Wait counter reads 1 on the first MEM_WAIT cycle because every RUN cycle preloads it
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     r_wait_cnt <= '0;
    else if (r_state == RUN)     r_wait_cnt <= TW'(1);
    else if (r_state == MEM_WAIT) r_wait_cnt <= r_wait_cnt + TW'(1);
  end

  // Sticky timeout flag, raised as the FSM enters ERR
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                           r_mem_err <= 1'b0;
    else if (r_state == MEM_WAIT && w_next_state == ERR) r_mem_err <= 1'b1;
  end

  // Saturating counters: frozen-PC cycles and taken-branch flushes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (!pc_en && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_flush_inc && r_flush_cnt != '1) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign mem_err   = r_mem_err;
  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - scoreboard bench for pipe_hazard_ctrl with directed and random stimulus
module tb_pipe_hazard_ctrl;

  localparam int TO      = 4;
  localparam int CW      = 6;
  localparam int CNT_MAX = (1 << CW) - 1;

  typedef struct packed {
    logic       rst;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       mr;
    logic       br;
    logic       req;
    logic       ack;
  } stim_t;

  // ctrl = {dmem_req, pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_bubble}
  typedef struct packed {
    logic [7:0]  ctrl;
    logic        err;
    logic [CW-1:0] stall;
    logic [CW-1:0] flush;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] if_id_rs1, if_id_rs2, id_ex_rd;
  logic if_id_rs1_used, if_id_rs2_used, id_ex_mem_read, ex_branch_taken, ex_mem_mem_req, dmem_ack;
  logic dmem_req, pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_bubble, mem_err;
  logic [CW-1:0] stall_cnt, flush_cnt;

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;

  int m_stall = 0;
  int m_flush = 0;
  int m_wait  = 0;
  bit m_err   = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .if_id_rs1(if_id_rs1), .if_id_rs2(if_id_rs2),
    .if_id_rs1_used(if_id_rs1_used), .if_id_rs2_used(if_id_rs2_used),
    .id_ex_rd(id_ex_rd), .id_ex_mem_read(id_ex_mem_read),
    .ex_branch_taken(ex_branch_taken), .ex_mem_mem_req(ex_mem_mem_req), .dmem_ack(dmem_ack),
    .dmem_req(dmem_req), .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
    .id_ex_en(id_ex_en), .id_ex_flush(id_ex_flush), .ex_mem_en(ex_mem_en),
    .mem_wb_bubble(mem_wb_bubble), .mem_err(mem_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  function automatic stim_t mk(input logic r, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic u1, input logic u2, input logic [4:0] rd,
                               input logic mr, input logic br, input logic req, input logic ack);
    stim_t s;
    s.rst = r; s.rs1 = rs1; s.rs2 = rs2; s.u1 = u1; s.u2 = u2; s.rd = rd;
    s.mr = mr; s.br = br; s.req = req; s.ack = ack;
    return s;
  endfunction

  function automatic int sat(input int v);
    return (v < CNT_MAX) ? v + 1 : CNT_MAX;
  endfunction

  // Apply one cycle of inputs, predict this cycle's outputs, then advance to just past the next edge
  task automatic drive(input stim_t s);
    exp_t e;
    bit lu;
    rst = s.rst; if_id_rs1 = s.rs1; if_id_rs2 = s.rs2;
    if_id_rs1_used = s.u1; if_id_rs2_used = s.u2; id_ex_rd = s.rd;
    id_ex_mem_read = s.mr; ex_branch_taken = s.br; ex_mem_mem_req = s.req; dmem_ack = s.ack;
    lu = s.mr && (s.rd != 0) && ((s.u1 && s.rs1 == s.rd) || (s.u2 && s.rs2 == s.rd));
    e.err = m_err; e.stall = CW'(m_stall); e.flush = CW'(m_flush);
    if (s.rst) begin
      e.ctrl = 8'b0001_0101;
      e.err = 1'b0; e.stall = '0; e.flush = '0;
      m_stall = 0; m_flush = 0; m_wait = 0; m_err = 0;
    end else if (m_err) begin
      e.ctrl = 8'b0000_0001;
      m_stall = sat(m_stall);
    end else if (s.req && !s.ack) begin
      e.ctrl = 8'b1000_0001;
      m_wait++;
      if (m_wait >= TO) m_err = 1;
      m_stall = sat(m_stall);
    end else begin
      m_wait = 0;
      if (s.br) begin
        e.ctrl = {s.req, 7'b111_1110};
        m_flush = sat(m_flush);
      end else if (lu) begin
        e.ctrl = {s.req, 7'b000_1110};
        m_stall = sat(m_stall);
      end else begin
        e.ctrl = {s.req, 7'b110_1010};
      end
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(mk(0, 5'd1, 5'd2, 0, 0, 5'd0, 0, 0, 0, 0));
  endtask

  task automatic do_reset();
    drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  // Monitor: outputs are combinational, so every cycle is a presented response
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({dmem_req, pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_bubble} !== e.ctrl) begin
          failures++;
          $display("FAIL ctrl t=%0t got=%b want=%b", $time,
                   {dmem_req, pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_bubble}, e.ctrl);
        end
        checks++;
        if (mem_err !== e.err) begin
          failures++;
          $display("FAIL mem_err t=%0t got=%b want=%b", $time, mem_err, e.err);
        end
        checks++;
        if (stall_cnt !== e.stall) begin
          failures++;
          $display("FAIL stall_cnt t=%0t got=%0d want=%0d", $time, stall_cnt, e.stall);
        end
        checks++;
        if (flush_cnt !== e.flush) begin
          failures++;
          $display("FAIL flush_cnt t=%0t got=%0d want=%0d", $time, flush_cnt, e.flush);
        end
      end
    end
  end

  initial begin
    stim_t s;
    rst = 1'b1; if_id_rs1 = '0; if_id_rs2 = '0; if_id_rs1_used = 0; if_id_rs2_used = 0;
    id_ex_rd = '0; id_ex_mem_read = 0; ex_branch_taken = 0; ex_mem_mem_req = 0; dmem_ack = 0;
    @(posedge clk);
    #1;
    do_reset();
    idle(2);

    // reset arriving mid-wait
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    idle(2);

    // load-use on rs1, then rs2, then rd=x0 which must not stall
    drive(mk(0, 5'd5, 5'd7, 1, 1, 5'd5, 1, 0, 0, 0));
    idle(1);
    drive(mk(0, 5'd3, 5'd9, 1, 1, 5'd9, 1, 0, 0, 0));
    drive(mk(0, 5'd3, 5'd9, 1, 0, 5'd9, 1, 0, 0, 0));
    drive(mk(0, 5'd0, 5'd0, 1, 1, 5'd0, 1, 0, 0, 0));

    // branch beats load-use
    drive(mk(0, 5'd5, 5'd0, 1, 0, 5'd5, 1, 1, 0, 0));
    idle(1);

    // dmem ack after 3 wait cycles
    do_reset();
    for (int i = 0; i < 3; i++) drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
    idle(1);

    // dmem wait with branch held, ack after 2
    for (int i = 0; i < 2; i++) drive(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
    drive(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1));
    idle(1);

    // request withdrawn mid-wait: no error
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    idle(1);

    // ack on the last allowed cycle wins over timeout
    for (int i = 0; i < TO - 1; i++) drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
    idle(2);

    // timeout into ERR; ERR holds long enough to saturate stall_cnt
    for (int i = 0; i < TO; i++) drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    drive(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1));
    for (int i = 0; i < 70; i++) drive(mk(0, 5'd5, 5'd5, 1, 1, 5'd5, 1, i[0], 1, 0));
    do_reset();

    // flush counter saturation
    for (int i = 0; i < 70; i++) drive(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    do_reset();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      s.rst = ($urandom_range(0, 99) < 2);
      s.rs1 = 5'($urandom_range(0, 7));
      s.rs2 = 5'($urandom_range(0, 7));
      s.u1  = 1'($urandom_range(0, 1));
      s.u2  = 1'($urandom_range(0, 1));
      s.rd  = 5'($urandom_range(0, 7));
      s.mr  = ($urandom_range(0, 99) < 50);
      s.br  = ($urandom_range(0, 99) < 20);
      s.req = ($urandom_range(0, 99) < 35);
      s.ack = ($urandom_range(0, 99) < 45);
      drive(s);
    end

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain got=%0d want=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
